// File: rtl/hdlc_rx_pkg.sv
// rtl/hdlc_rx_pkg.sv - shared types and constants for the HDLC receive deframer
// Purpose: state and line-event enumerations plus the flag/stuffing run lengths
//          used by hdlc_flag_tracker and hdlc_rx_deframer.
// Ports:   none (package).
package hdlc_rx_pkg;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam int ONES_W    = 3;   // ones run counter, saturates at 7
  localparam int STUFF_RUN = 5;   // a 0 after five 1s is a stuffed bit
  localparam int FLAG_RUN  = 6;   // a 0 after six 1s closes a flag
  localparam int DLY_LEN   = 6;   // bits held back until they cannot be part of a flag

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    DATA
  } hdlc_state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_STUFF,
    EV_SIXTH,
    EV_FLAG,
    EV_ABORT
  } hdlc_ev_e;

endpackage

// File: rtl/hdlc_flag_tracker.sv
// rtl/hdlc_flag_tracker.sv - consecutive-ones counter and line event decode
// Purpose: counts the current run of 1s on the line and classifies each valid
//          bit as plain data, stuffed zero, sixth one, flag or abort.
// Ports:   clk_i, rst_i (sync, active-high), bit_i/vld_i line bit and strobe,
//          ev_o event for the current bit (EV_NONE when vld_i is low).
module hdlc_flag_tracker
  import hdlc_rx_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     bit_i,
  input  logic     vld_i,
  output hdlc_ev_e ev_o
);

  logic [ONES_W-1:0] ones_q, ones_d;

  // Events are decoded from the run length before this bit is counted.
  always_comb begin
    ev_o = EV_NONE;
    if (vld_i) begin
      if (!bit_i) begin
        if (ones_q == ONES_W'(FLAG_RUN))       ev_o = EV_FLAG;
        else if (ones_q == ONES_W'(STUFF_RUN)) ev_o = EV_STUFF;
      end else begin
        if (ones_q == ONES_W'(FLAG_RUN))       ev_o = EV_ABORT;
        else if (ones_q == ONES_W'(STUFF_RUN)) ev_o = EV_SIXTH;
      end
    end
  end

  always_comb begin
    ones_d = '0;
    if (bit_i) ones_d = (ones_q == '1) ? ones_q : ones_q + 1'b1;
  end

  // Starts saturated so that a line coming out of reset must show a 0
  // before six 1s can be read as a flag.
  always_ff @(posedge clk_i) begin
    if (rst_i)      ones_q <= '1;
    else if (vld_i) ones_q <= ones_d;
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// rtl/hdlc_rx_deframer.sv - HDLC receive deframer: flag hunt, destuffing, byte assembly
// Purpose: hunts for flags on a zero-stuffed serial line, strips stuffed zeros,
//          assembles bytes LSB-first and delimits frames with sof/eof; reports
//          aborts and malformed or over-length frames.
// Ports:   clk, rst (sync, active-high); bit_in/bit_vld serial input;
//          byte_out/byte_vld/sof/eof byte stream; abort, frame_err pulses;
//          in_frame level. With HDLC_RX_STATS_EN defined: good_frames,
//          abort_cnt, err_cnt saturating statistics counters.
// Macro:   HDLC_RX_STATS_EN enables the statistics counters and their ports.
module hdlc_rx_deframer
  import hdlc_rx_pkg::*;
#(
  parameter int MAX_BYTES = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic [7:0]       byte_out,
  output logic             byte_vld,
  output logic             sof,
  output logic             eof,
  output logic             abort,
  output logic             frame_err,
  output logic             in_frame
`ifdef HDLC_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] abort_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int BCNT_W    = $clog2(MAX_BYTES + 2);
  localparam int DLY_CNT_W = $clog2(DLY_LEN + 1);

  hdlc_ev_e ev;

  hdlc_flag_tracker u_tracker (
    .clk_i (clk),
    .rst_i (rst),
    .bit_i (bit_in),
    .vld_i (bit_vld),
    .ev_o  (ev)
  );

  hdlc_state_e          state_q, state_d;
  logic [DLY_LEN-1:0]   dly_q, dly_d;
  logic [DLY_CNT_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [7:0]           asm_q, asm_d;
  logic [2:0]           asm_cnt_q, asm_cnt_d;
  logic [7:0]           pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [BCNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]           byte_out_q, byte_out_d;
  logic                 byte_vld_q, byte_vld_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 abort_q, abort_d;
  logic                 ferr_q, ferr_d;
  logic                 in_frame_q, in_frame_d;

  logic                 commit_vld;
  logic                 commit_bit;
  logic                 drop_all;

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    dly_cnt_d  = dly_cnt_q;
    asm_d      = asm_q;
    asm_cnt_d  = asm_cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    byte_cnt_d = byte_cnt_q;
    byte_out_d = byte_out_q;
    byte_vld_d = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    abort_d    = 1'b0;
    ferr_d     = 1'b0;
    commit_vld = 1'b0;
    commit_bit = 1'b0;
    drop_all   = 1'b0;

    if (bit_vld) begin
      case (state_q)
        HUNT: begin
          if (ev == EV_FLAG) begin
            state_d  = SYNC;
            drop_all = 1'b1;
          end
        end
        default: begin
          case (ev)
            EV_FLAG: begin
              // A clean close needs byte alignment and at least one byte waiting.
              if (state_q == DATA) begin
                if (asm_cnt_q == 3'd0 && pend_vld_q) begin
                  byte_out_d = pend_q;
                  byte_vld_d = 1'b1;
                  eof_d      = 1'b1;
                  sof_d      = (byte_cnt_q == BCNT_W'(1));
                end else begin
                  ferr_d = 1'b1;
                end
              end
              state_d  = SYNC;
              drop_all = 1'b1;
            end
            EV_ABORT: begin
              abort_d  = (state_q == DATA);
              state_d  = HUNT;
              drop_all = 1'b1;
            end
            EV_SIXTH: begin
              // The held-back 0 and five 1s belong to a flag or abort.
              dly_cnt_d = '0;
              dly_d     = '0;
            end
            EV_NONE: begin
              dly_d = {dly_q[DLY_LEN-2:0], bit_in};
              if (dly_cnt_q == DLY_CNT_W'(DLY_LEN)) begin
                commit_vld = 1'b1;
                commit_bit = dly_q[DLY_LEN-1];
              end else begin
                dly_cnt_d = dly_cnt_q + 1'b1;
              end
            end
            default: begin
              // stuffed zero: dropped
            end
          endcase
        end
      endcase
    end

    if (commit_vld) begin
      state_d          = DATA;
      asm_d[asm_cnt_q] = commit_bit;
      if (asm_cnt_q == 3'd7) begin
        asm_cnt_d = 3'd0;
        if (byte_cnt_q == BCNT_W'(MAX_BYTES)) begin
          // This byte would be number MAX_BYTES+1.
          ferr_d   = 1'b1;
          state_d  = HUNT;
          drop_all = 1'b1;
        end else begin
          // Pend only leaves once the next byte proves it is not the last one.
          if (pend_vld_q) begin
            byte_out_d = pend_q;
            byte_vld_d = 1'b1;
            sof_d      = (byte_cnt_q == BCNT_W'(1));
          end
          pend_d     = asm_d;
          pend_vld_d = 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end else begin
        asm_cnt_d = asm_cnt_q + 1'b1;
      end
    end

    if (drop_all) begin
      dly_d      = '0;
      dly_cnt_d  = '0;
      asm_d      = '0;
      asm_cnt_d  = '0;
      pend_d     = '0;
      pend_vld_d = 1'b0;
      byte_cnt_d = '0;
    end

    in_frame_d = (state_d == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      dly_q      <= '0;
      dly_cnt_q  <= '0;
      asm_q      <= '0;
      asm_cnt_q  <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      byte_cnt_q <= '0;
      byte_out_q <= '0;
      byte_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      abort_q    <= 1'b0;
      ferr_q     <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      dly_cnt_q  <= dly_cnt_d;
      asm_q      <= asm_d;
      asm_cnt_q  <= asm_cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      byte_cnt_q <= byte_cnt_d;
      byte_out_q <= byte_out_d;
      byte_vld_q <= byte_vld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      abort_q    <= abort_d;
      ferr_q     <= ferr_d;
      in_frame_q <= in_frame_d;
    end
  end

  assign byte_out  = byte_out_q;
  assign byte_vld  = byte_vld_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign abort     = abort_q;
  assign frame_err = ferr_q;
  assign in_frame  = in_frame_q;

`ifdef HDLC_RX_STATS_EN
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] abrt_q, abrt_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  always_comb begin
    good_d = good_q;
    abrt_d = abrt_q;
    errc_d = errc_q;
    if (byte_vld_d && eof_d && good_q != '1) good_d = good_q + 1'b1;
    if (abort_d && abrt_q != '1)             abrt_d = abrt_q + 1'b1;
    if (ferr_d && errc_q != '1)              errc_d = errc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_q <= '0;
      abrt_q <= '0;
      errc_q <= '0;
    end else begin
      good_q <= good_d;
      abrt_q <= abrt_d;
      errc_q <= errc_d;
    end
  end

  assign good_frames = good_q;
  assign abort_cnt   = abrt_q;
  assign err_cnt     = errc_q;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb/tb_hdlc_rx_deframer.sv - directed self-checking bench for hdlc_rx_deframer
module tb_hdlc_rx_deframer;

  logic clk = 1'b0;
  logic rst;
  logic bit_in;
  logic bit_vld;

  logic [7:0] byte_out, byte_out4;
  logic byte_vld, sof, eof, abort, frame_err, in_frame;
  logic byte_vld4, sof4, eof4, abort4, frame_err4, in_frame4;
`ifdef HDLC_RX_STATS_EN
  logic [15:0] good_frames, abort_cnt, err_cnt;
  logic [15:0] good_frames4, abort_cnt4, err_cnt4;
`endif

  hdlc_rx_deframer #(.MAX_BYTES(256), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
    .byte_out(byte_out), .byte_vld(byte_vld), .sof(sof), .eof(eof),
    .abort(abort), .frame_err(frame_err), .in_frame(in_frame)
`ifdef HDLC_RX_STATS_EN
    , .good_frames(good_frames), .abort_cnt(abort_cnt), .err_cnt(err_cnt)
`endif
  );

  hdlc_rx_deframer #(.MAX_BYTES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
    .byte_out(byte_out4), .byte_vld(byte_vld4), .sof(sof4), .eof(eof4),
    .abort(abort4), .frame_err(frame_err4), .in_frame(in_frame4)
`ifdef HDLC_RX_STATS_EN
    , .good_frames(good_frames4), .abort_cnt(abort_cnt4), .err_cnt(err_cnt4)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gap_en = 0;
  int tx_ones = 0;
  int n_abort, n_ferr, n_abort4, n_ferr4;
  int overlap = 0;
  logic [9:0] rx_q[$];
  logic [9:0] rx4_q[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic clear_mon();
    rx_q.delete();
    rx4_q.delete();
    n_abort = 0; n_ferr = 0; n_abort4 = 0; n_ferr4 = 0;
  endtask

  // One clock: drive inputs, let the edge pass, then sample registered outputs.
  task automatic tick(input logic v, input logic b);
    bit_vld = v;
    bit_in  = b;
    @(posedge clk);
    #1;
    bit_vld = 1'b0;
    if (byte_vld)  rx_q.push_back({sof, eof, byte_out});
    if (abort)     n_abort++;
    if (frame_err) n_ferr++;
    if (byte_vld4)  rx4_q.push_back({sof4, eof4, byte_out4});
    if (abort4)     n_abort4++;
    if (frame_err4) n_ferr4++;
    if (int'(byte_vld) + int'(abort) + int'(frame_err) > 1) overlap++;
    if (int'(byte_vld4) + int'(abort4) + int'(frame_err4) > 1) overlap++;
  endtask

  task automatic send_bit(input logic b);
    tick(1'b1, b);
    if (gap_en != 0) tick(1'b0, ~b);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_data_bit(d[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bit_vld = 1'b0;
    bit_in = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    checks++; if (byte_vld !== 1'b0) begin errors++; $display("FAIL reset_byte_vld got %b exp 0", byte_vld); end
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL reset_sof got %b exp 0", sof); end
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL reset_eof got %b exp 0", eof); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b exp 0", abort); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL reset_in_frame got %b exp 0", in_frame); end
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out got %h exp 00", byte_out); end
    checks++; if (in_frame4 !== 1'b0) begin errors++; $display("FAIL reset_in_frame4 got %b exp 0", in_frame4); end
  endtask

  task automatic test_single_byte();
    logic [7:0] f;
    f = 8'h7E;
    clear_mon();
    repeat (10) send_bit(1'b1);
    send_flag();
    send_byte(8'hA5);
    for (int i = 0; i < 7; i++) send_bit(f[i]);
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL single_early_bytes got %0d exp 0", rx_q.size()); end
    checks++; if (in_frame !== 1'b1) begin errors++; $display("FAIL single_in_frame got %b exp 1", in_frame); end
    tick(1'b1, 1'b0);
    tx_ones = 0;
    checks++; if (byte_vld !== 1'b1) begin errors++; $display("FAIL single_byte_vld got %b exp 1", byte_vld); end
    checks++; if (byte_out !== 8'hA5) begin errors++; $display("FAIL single_byte_out got %h exp a5", byte_out); end
    checks++; if ({sof, eof} !== 2'b11) begin errors++; $display("FAIL single_sof_eof got %b exp 11", {sof, eof}); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL single_in_frame_after got %b exp 0", in_frame); end
    tick(1'b0, 1'b0);
    checks++; if (byte_vld !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", byte_vld); end
  endtask

  task automatic test_stuffed(input string tag);
    clear_mon();
    send_flag();
    send_byte(8'h7E);
    send_byte(8'h01);
    send_flag();
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL %s_count got %0d exp 2", tag, rx_q.size()); end
    checks++; if (rx_q[0] !== {1'b1, 1'b0, 8'h7E}) begin errors++; $display("FAIL %s_byte0 got %h exp %h", tag, rx_q[0], {1'b1, 1'b0, 8'h7E}); end
    checks++; if (rx_q[1] !== {1'b0, 1'b1, 8'h01}) begin errors++; $display("FAIL %s_byte1 got %h exp %h", tag, rx_q[1], {1'b0, 1'b1, 8'h01}); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL %s_ferr got %0d exp 0", tag, n_ferr); end
  endtask

  task automatic test_abort();
    clear_mon();
    send_flag();
    send_byte(8'h3C);
    repeat (7) send_bit(1'b1);
    checks++; if (n_abort !== 1) begin errors++; $display("FAIL abort_count got %0d exp 1", n_abort); end
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL abort_bytes got %0d exp 0", rx_q.size()); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL abort_in_frame got %b exp 0", in_frame); end
    tx_ones = 0;
    send_byte(8'h55);
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL abort_hunt_bytes got %0d exp 0", rx_q.size()); end
    send_flag();
    send_byte(8'h55);
    send_flag();
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL abort_next_count got %0d exp 1", rx_q.size()); end
    checks++; if (rx_q[0] !== {1'b1, 1'b1, 8'h55}) begin errors++; $display("FAIL abort_next_byte got %h exp %h", rx_q[0], {1'b1, 1'b1, 8'h55}); end
    checks++; if (n_abort !== 1) begin errors++; $display("FAIL abort_total got %0d exp 1", n_abort); end
  endtask

  task automatic test_frame_err();
    logic [10:0] bits;
    bits = 11'b00101001101;  // sent from bit 0 upward: 1,0,1,1,0,0,1,0,1,0,0
    clear_mon();
    send_flag();
    for (int i = 0; i < 11; i++) send_data_bit(bits[i]);
    send_flag();
    checks++; if (n_ferr !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", n_ferr); end
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL ferr_bytes got %0d exp 0", rx_q.size()); end
    send_byte(8'h55);
    send_flag();
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL ferr_next_count got %0d exp 1", rx_q.size()); end
    checks++; if (rx_q[0] !== {1'b1, 1'b1, 8'h55}) begin errors++; $display("FAIL ferr_next_byte got %h exp %h", rx_q[0], {1'b1, 1'b1, 8'h55}); end
    checks++; if (n_ferr !== 1) begin errors++; $display("FAIL ferr_total got %0d exp 1", n_ferr); end
  endtask

  task automatic test_max_bytes();
    clear_mon();
    send_flag();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_flag();
    checks++; if (rx4_q.size() !== 3) begin errors++; $display("FAIL max_count got %0d exp 3", rx4_q.size()); end
    checks++; if (rx4_q[0] !== {1'b1, 1'b0, 8'h11}) begin errors++; $display("FAIL max_byte0 got %h exp %h", rx4_q[0], {1'b1, 1'b0, 8'h11}); end
    checks++; if (rx4_q[2] !== {1'b0, 1'b0, 8'h33}) begin errors++; $display("FAIL max_byte2 got %h exp %h", rx4_q[2], {1'b0, 1'b0, 8'h33}); end
    checks++; if (n_ferr4 !== 1) begin errors++; $display("FAIL max_ferr got %0d exp 1", n_ferr4); end
    checks++; if (in_frame4 !== 1'b0) begin errors++; $display("FAIL max_in_frame got %b exp 0", in_frame4); end
    checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL big_count got %0d exp 5", rx_q.size()); end
    checks++; if (rx_q[4] !== {1'b0, 1'b1, 8'h55}) begin errors++; $display("FAIL big_last got %h exp %h", rx_q[4], {1'b0, 1'b1, 8'h55}); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL big_ferr got %0d exp 0", n_ferr); end
  endtask

  task automatic test_gaps_rst();
    gap_en = 1;
    test_stuffed("gap");
    clear_mon();
    send_flag();
    send_byte(8'h3C);
    checks++; if (in_frame !== 1'b1) begin errors++; $display("FAIL rst_pre_in_frame got %b exp 1", in_frame); end
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL rst_in_frame got %b exp 0", in_frame); end
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL rst_byte_out got %h exp 00", byte_out); end
    checks++; if ({byte_vld, sof, eof, abort, frame_err} !== 5'b0) begin errors++; $display("FAIL rst_pulses got %b exp 00000", {byte_vld, sof, eof, abort, frame_err}); end
`ifdef HDLC_RX_STATS_EN
    checks++; if (good_frames !== 16'd0) begin errors++; $display("FAIL rst_good_frames got %0d exp 0", good_frames); end
`endif
    tx_ones = 0;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_byte(8'hA5);
    send_flag();
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rst_unprefixed_bytes got %0d exp 0", rx_q.size()); end
    checks++; if (n_ferr + n_abort !== 0) begin errors++; $display("FAIL rst_unprefixed_pulses got %0d exp 0", n_ferr + n_abort); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL rst_unprefixed_in_frame got %b exp 0", in_frame); end
    gap_en = 0;
  endtask

  task automatic test_exclusive();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuffed("stuffed");
    test_abort();
    test_frame_err();
    test_max_bytes();
    test_gaps_rst();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
